// File: rtl/mem_store_checker_if.sv
// Store bus between the MIPS core and mem_store_checker.
// The core drives the store strobe, address and data. The checker drives the core reset.
interface mem_store_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;
  logic              dut_reset;

  modport master (output memwrite, dataadr, writedata, input  dut_reset);
  modport slave  (input  memwrite, dataadr, writedata, output dut_reset);
endinterface

// File: rtl/mem_store_checker.sv
// mem_store_checker: runs a sequence of NUM_TESTS core runs. Each run works as follows:
// - The core is held in reset for RST_CYCLES cycles.
// - The store bus is then watched for TEST_CYCLES cycles.
// - The run passes if any store matched the expected (exp_addr, exp_data) of the current test.
// Optional feature: define MISMATCH_LOG_EN to capture the first mismatching store after start.
module mem_store_checker #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_TESTS   = 11,
  parameter int TEST_CYCLES = 100,
  parameter int RST_CYCLES  = 2,
  localparam int CNT_W      = $clog2(NUM_TESTS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  mem_store_checker_if.slave bus,
  input  logic [ADDR_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0]  exp_data,
  output logic [CNT_W-1:0]   test_idx,
  output logic               test_pass,
  output logic               test_fail,
  output logic               mismatch_pulse,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count,
  output logic [15:0]        mismatch_count,
  output logic               done,
  output logic [ADDR_W-1:0]  log_addr,
  output logic [DATA_W-1:0]  log_data
);

  localparam int CYC_W = (TEST_CYCLES > 2) ? $clog2(TEST_CYCLES) : 1;
  localparam int RC_W  = (RST_CYCLES > 1)  ? $clog2(RST_CYCLES)  : 1;

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CYC_W-1:0] cyc;
  logic [RC_W-1:0]  rst_cnt;
  logic             hit;

  logic in_run, store_ok, store_bad, last_cyc, last_idx, rst_end, go, live;

  assign in_run    = (state == S_RUN);
  assign store_ok  = bus.memwrite && (bus.dataadr == exp_addr) && (bus.writedata == exp_data);
  assign store_bad = bus.memwrite && !store_ok;
  assign last_cyc  = (cyc == CYC_W'(TEST_CYCLES - 1));
  assign last_idx  = (test_idx == CNT_W'(NUM_TESTS - 1));
  assign rst_end   = (rst_cnt == RC_W'(RST_CYCLES - 1));
  // start only counts in IDLE/DONE, and abort always wins over it
  assign go        = start && !abort && (state == S_IDLE || state == S_DONE);
  // an observed run cycle that will not be thrown away by abort
  assign live      = in_run && !abort;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next state, core reset and done flag
  always_comb begin
    state_nx      = state;
    bus.dut_reset = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE: if (go) state_nx = S_RST;
      S_RST:  if (rst_end) state_nx = S_RUN;
      S_RUN: begin
        bus.dut_reset = 1'b0;
        if (last_cyc) state_nx = last_idx ? S_DONE : S_RST;
      end
      S_DONE: begin
        done = 1'b1;
        if (go) state_nx = S_RST;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // reset-hold and observation-window timers, plus per-run hit flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_cnt <= '0;
      cyc     <= '0;
      hit     <= 1'b0;
    end else begin
      rst_cnt <= (state == S_RST) ? rst_cnt + 1'b1 : '0;
      cyc     <= in_run ? cyc + 1'b1 : '0;
      if (!in_run)       hit <= 1'b0;
      else if (store_ok) hit <= 1'b1;
    end
  end

  // verdicts, run index, sequence counters and 1-cycle pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      test_idx       <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      mismatch_count <= '0;
      test_pass      <= 1'b0;
      test_fail      <= 1'b0;
      mismatch_pulse <= 1'b0;
    end else begin
      test_pass      <= 1'b0;
      test_fail      <= 1'b0;
      mismatch_pulse <= 1'b0;
      if (go) begin
        test_idx       <= '0;
        pass_count     <= '0;
        fail_count     <= '0;
        mismatch_count <= '0;
      end else if (live) begin
        if (store_bad) begin
          mismatch_pulse <= 1'b1;
          if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
        end
        if (last_cyc) begin
          // a match landing on the final window cycle still counts
          if (hit || store_ok) begin
            test_pass  <= 1'b1;
            pass_count <= pass_count + 1'b1;
          end else begin
            test_fail  <= 1'b1;
            fail_count <= fail_count + 1'b1;
          end
          if (!last_idx) test_idx <= test_idx + 1'b1;
        end
      end
    end
  end

`ifdef MISMATCH_LOG_EN
  logic log_vld;

  // keep the first mismatching store seen since the last start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      log_vld  <= 1'b0;
      log_addr <= '0;
      log_data <= '0;
    end else if (go) begin
      log_vld  <= 1'b0;
      log_addr <= '0;
      log_data <= '0;
    end else if (live && store_bad && !log_vld) begin
      log_vld  <= 1'b1;
      log_addr <= bus.dataadr;
      log_data <= bus.writedata;
    end
  end
`else
  assign log_addr = '0;
  assign log_data = '0;
`endif

endmodule
